// File: rtl/encrypt_pkg.sv
// Shared types and constants for the encryption front end: FSM states,
// block geometry and the default core latency.
package encrypt_pkg;

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_TEXT = 2'd1,
    WAIT      = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  localparam int         WORDS_PER_BLOCK     = 4;
  localparam int         DEFAULT_WAIT_CYCLES = 14;
  localparam logic [1:0] LAST_WORD           = 2'(WORDS_PER_BLOCK - 1);

  // Word idx of a 128-bit block, word 0 being the most-significant.
  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/encrypt_frontend_latency_timer.sv
// Fixed-latency timer: done is high in the WAIT_CYCLES-th cycle counted from
// (and including) the cycle start is high.
module latency_timer
  import encrypt_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam logic [7:0] LAST_COUNT = 8'(WAIT_CYCLES - 1);
  localparam logic       SINGLE     = (WAIT_CYCLES == 1);

  logic       busy;
  logic [7:0] count;

  // count holds how many cycles have already elapsed before the current one.
  assign done = start ? SINGLE : (busy && (count == LAST_COUNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= 8'd0;
    end else if (done) begin
      busy  <= 1'b0;
      count <= 8'd0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= 8'd1;
    end else if (busy) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/encrypt_frontend.sv
// Word-serial front end for a 128-bit block cipher core: loads key and text,
// waits a fixed core latency, then drains the ciphertext word by word.
// Optional ENCRYPT_FRONTEND_KEY_REUSE_EN adds key_hold to skip key reloads.
module encrypt_frontend
  import encrypt_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  output logic         core_start,
  input  logic [127:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data
`ifdef ENCRYPT_FRONTEND_KEY_REUSE_EN
  ,
  input  logic         key_hold
`endif
);

  state_t       state;
  logic [1:0]   word_cnt;
  logic [127:0] result_q;
  logic         wait_done;
  logic         in_xfer;
  logic         reuse_key;

  // Both directions use plain valid/ready: a word moves on a rising edge
  // where valid and ready are both high; ready is registered from state.
  assign in_xfer = in_valid && in_ready;

`ifdef ENCRYPT_FRONTEND_KEY_REUSE_EN
  assign reuse_key = key_hold;
`else
  assign reuse_key = 1'b0;
`endif

  latency_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (reset),
    .start(core_start),
    .done (wait_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD_KEY;
      word_cnt   <= 2'd0;
      core_key   <= '0;
      core_text  <= '0;
      result_q   <= '0;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      in_ready   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        LOAD_KEY: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            core_key <= {core_key[95:0], in_data};
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == LAST_WORD) state <= LOAD_TEXT;
          end
        end
        LOAD_TEXT: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            core_text <= {core_text[95:0], in_data};
            word_cnt  <= word_cnt + 2'd1;
            if (word_cnt == LAST_WORD) begin
              state      <= WAIT;
              core_start <= 1'b1;
              in_ready   <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (wait_done) begin
            result_q  <= core_result;
            out_data  <= core_result[127:96];
            out_valid <= 1'b1;
            word_cnt  <= 2'd0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt  <= 2'd0;
              out_valid <= 1'b0;
              out_data  <= '0;
              in_ready  <= 1'b1;
              state     <= reuse_key ? LOAD_TEXT : LOAD_KEY;
            end else begin
              word_cnt <= word_cnt + 2'd1;
              out_data <= word_of(result_q, word_cnt + 2'd1);
            end
          end
        end
        default: state <= LOAD_KEY;
      endcase
    end
  end

endmodule
